// File: rtl/pwm_multi_pkg.sv
// Shared constants for the multi-channel PWM: register word offsets (addr[7:2]),
// CTRL bit positions and the byte-strobe merge helper used by the bus decoder.
package pwm_multi_pkg;

  localparam logic [5:0] REG_CTRL     = 6'h00;
  localparam logic [5:0] REG_PRESCALE = 6'h01;
  localparam logic [5:0] REG_PERIOD   = 6'h02;
  localparam logic [5:0] REG_POL      = 6'h03;
  localparam logic [5:0] REG_STATUS   = 6'h04;
  localparam logic [5:0] REG_COUNT    = 6'h05;
  localparam logic [5:0] REG_DUTY0    = 6'h08;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Replace only the strobed bytes of the current register value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? data[8*b +: 8] : cur[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: compares the shared counter against this channel's active
// duty, applies polarity, and parks at the idle level while the block is disabled.
module pwm_channel #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] duty,
  input  logic          pol,
  input  logic          idle,
  output logic          out
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) out <= 1'b0;
    else if (!en) out <= idle;
    else          out <= (cnt < duty) ^ pol;
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a simple valid/ready register bus, shared prescaler and
// period counter, shadowed PERIOD/POL/DUTY that take effect only at period wrap.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           valid,
  output logic           ready,
  input  logic [3:0]     wstrb,
  input  logic [31:0]    addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic [NCH-1:0] out,
  output logic           irq
);

  logic [1:0]     ctrl;
  logic [15:0]    prescale, pre;
  logic [CW-1:0]  period_sh, period_act, cnt;
  logic [NCH-1:0] pol_sh, pol_act;
  logic [CW-1:0]  duty_sh  [NCH];
  logic [CW-1:0]  duty_act [NCH];
  logic           wrap_flag;

  logic [5:0]  widx;
  logic [31:0] cur_val, wr_word;
  logic        wr_en, rd_req, wrap_clr;
  logic        en, tick, wrap_evt;
  logic        unused_bits;

  assign widx     = addr[7:2];
  assign wr_en    = valid && ready && (wstrb != 4'b0);
  assign rd_req   = valid && !ready && (wstrb == 4'b0);
  assign wrap_clr = wr_en && (widx == REG_STATUS) && wstrb[0] && wdata[0];
  assign wr_word  = merge_bytes(cur_val, wdata, wstrb);

  assign en       = ctrl[CTRL_EN];
  assign tick     = en && (pre >= prescale);
  assign wrap_evt = tick && (cnt == period_act);

  assign unused_bits = ^{addr[31:8], addr[1:0], wr_word};

  // NOTE: cur_val gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    cur_val = '0;
    case (widx)
      REG_CTRL:     cur_val = {30'b0, ctrl};
      REG_PRESCALE: cur_val = {16'b0, prescale};
      REG_PERIOD:   cur_val = 32'(period_sh);
      REG_POL:      cur_val = 32'(pol_sh);
      REG_STATUS:   cur_val = {31'b0, wrap_flag};
      REG_COUNT:    cur_val = 32'(cnt);
      default: begin
        for (int i = 0; i < NCH; i++)
          if (widx == REG_DUTY0 + 6'(i)) cur_val = 32'(duty_sh[i]);
      end
    endcase
  end

  // Bus side: handshake, read capture and software-visible registers.
  // NOTE: the small duty register arrays are reset like ordinary flops so they start at 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready     <= 1'b0;
      rdata     <= '0;
      ctrl      <= '0;
      prescale  <= '0;
      period_sh <= '0;
      pol_sh    <= '0;
      for (int i = 0; i < NCH; i++) duty_sh[i] <= '0;
    end else begin
      ready <= valid && !ready;
      rdata <= rd_req ? cur_val : '0;
      if (wr_en) begin
        case (widx)
          REG_CTRL:     ctrl      <= wr_word[1:0];
          REG_PRESCALE: prescale  <= wr_word[15:0];
          REG_PERIOD:   period_sh <= wr_word[CW-1:0];
          REG_POL:      pol_sh    <= wr_word[NCH-1:0];
          default: begin
            for (int i = 0; i < NCH; i++)
              if (widx == REG_DUTY0 + 6'(i)) duty_sh[i] <= wr_word[CW-1:0];
          end
        endcase
      end
    end
  end

  // Timebase: prescaler, period counter, shadow->active load, wrap status and irq.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre        <= '0;
      cnt        <= '0;
      period_act <= '0;
      pol_act    <= '0;
      for (int i = 0; i < NCH; i++) duty_act[i] <= '0;
      wrap_flag  <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (!en) begin
        pre <= '0;
        cnt <= '0;
      end else if (tick) begin
        // pre >= prescale also catches a PRESCALE shrunk below the running count.
        pre <= '0;
        cnt <= wrap_evt ? '0 : cnt + CW'(1);
      end else begin
        pre <= pre + 16'd1;
      end

      if (!en || wrap_evt) begin
        period_act <= period_sh;
        pol_act    <= pol_sh;
        for (int i = 0; i < NCH; i++) duty_act[i] <= duty_sh[i];
      end

      if (wrap_evt)      wrap_flag <= 1'b1;
      else if (wrap_clr) wrap_flag <= 1'b0;

      irq <= wrap_flag && ctrl[CTRL_IRQ_EN];
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_channel #(.CW(CW)) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .en     (en),
      .cnt    (cnt),
      .duty   (duty_act[i]),
      .pol    (pol_act[i]),
      .idle   (pol_sh[i]),
      .out    (out[i])
    );
  end

endmodule
